// File: rtl/router_pkg.sv
// Shared router definitions: port count, word width, arbiter state encoding.
// No logic; sized constants used by the egress arbiter and its priority encoder.
// Backpressure: not applicable.
package router_pkg;

    localparam int NUM_PORTS = 8;
    localparam int DATA_W    = 32;
    localparam int PTR_W     = $clog2(NUM_PORTS);

    // Arbiter state encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set req bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; winner is re-evaluated every cycle from req and ptr.
module rr_pick
    import router_pkg::*;
#(
    parameter int N  = NUM_PORTS,
    parameter int PW = PTR_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            // Modulo-N wrap done by subtraction so N need not be a power of two
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/egress_arbiter.sv
// Packet arbiter: round-robin grant of one selector per packet, muxed into one egress FIFO.
// Latency: grant one cycle after request in IDLE; data path is combinational from the grant.
// Backpressure: fifo_full blocks req_ready/fifo_push; a silent owner loses its grant after TIMEOUT cycles.
module egress_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ = NUM_PORTS,
    parameter int DATA_W  = router_pkg::DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      timeout_err
);

    localparam int              PW        = $clog2(NUM_REQ);
    localparam int              CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   STALL_MAX = CW'(TIMEOUT - 1);

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      stall_q, stall_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_REQ-1:0] pick_winner;
    logic               pick_any;
    logic [PW-1:0]      owner_idx;
    logic [PW-1:0]      next_ptr;
    logic               owner_vld;
    logic               owner_last;
    logic [DATA_W-1:0]  owner_dat;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // AND-OR mux keyed by the one-hot grant; yields zero when idle
    always_comb begin
        owner_idx = '0;
        owner_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PW'(i);
            end
            owner_dat = owner_dat | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
        end
        owner_vld  = |(grant_q & req_valid);
        owner_last = |(grant_q & req_last);
        next_ptr   = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + PW'(1);
    end

    assign req_ready   = grant_q & req_valid & {NUM_REQ{~fifo_full}};
    assign fifo_push   = |req_ready;
    assign fifo_din    = owner_dat;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        stall_d       = stall_q;
        timeout_err_d = 1'b0;
        if (state_q == IDLE) begin
            if (pick_any) begin
                grant_d = pick_winner;
                stall_d = '0;
                state_d = XFER;
            end
        end else begin
            if (owner_vld) begin
                stall_d = '0;
                if (!fifo_full && owner_last) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end else if (stall_q == STALL_MAX) begin
                // Owner went silent too long: revoke and let the others in
                grant_d       = '0;
                rr_ptr_d      = next_ptr;
                stall_d       = '0;
                timeout_err_d = 1'b1;
                state_d       = IDLE;
            end else begin
                stall_d = stall_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            stall_q       <= stall_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_egress_arbiter.sv
// Self-checking bench for egress_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a packet-level reference model.
module tb_egress_arbiter;

    localparam int N   = 8;
    localparam int W   = 32;
    localparam int TMO = 64;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_push;
    logic [W-1:0]   fifo_din;
    logic [N-1:0]   grant;
    logic           timeout_err;

    egress_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W),
        .TIMEOUT (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_push   (fifo_push),
        .fifo_din    (fifo_din),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks   = 0;
    int failures = 0;

    // Packet sources: words remaining, packet id, word index, forced silence, auto-refill length
    int src_len[N];
    int src_pkt[N];
    int src_widx[N];
    bit src_hold[N];
    int src_refill[N];
    bit rand_mode;
    int gap_pct;
    int full_pct;

    logic [N-1:0] obs_ready;
    logic [N-1:0] last_grant;
    int           order_q[$];

    // Reference model: owner (-1 = nobody), round-robin pointer, silent-cycle count, error pulse
    int m_owner, m_ptr, m_stall;
    bit m_tmo;
    int n_owner, n_ptr, n_stall;
    bit n_tmo;
    logic [N-1:0] exp_grant, exp_ready;
    logic         exp_push, exp_tmo;
    logic [W-1:0] exp_din;

    function automatic logic [W-1:0] word_of(int i, int pkt, int widx);
        return {i[7:0], pkt[7:0], widx[15:0]};
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_srcs();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0; src_widx[i] = 0; src_hold[i] = 1'b0; src_refill[i] = 0;
        end
    endtask

    task automatic src_drive();
        bit v;
        for (int i = 0; i < N; i++) begin
            v = (src_len[i] > 0) && !src_hold[i] && !(rand_mode && ($urandom_range(99) < gap_pct));
            req_valid[i]          = v;
            req_last[i]           = v ? (src_len[i] == 1) : 1'($urandom);
            req_data[i*W +: W]    = v ? word_of(i, src_pkt[i], src_widx[i]) : $urandom;
        end
        if (rand_mode) fifo_full = ($urandom_range(99) < full_pct);
    endtask

    task automatic src_update();
        for (int i = 0; i < N; i++) begin
            if (!reset && obs_ready[i]) begin
                src_widx[i]++;
                src_len[i]--;
                if (src_len[i] == 0) begin
                    src_pkt[i]++;
                    src_widx[i] = 0;
                end
            end
            if (src_len[i] == 0) begin
                if (src_refill[i] > 0) src_len[i] = src_refill[i];
                else if (rand_mode && $urandom_range(9) == 0) src_len[i] = $urandom_range(1, 5);
            end
        end
    endtask

    task automatic model_eval();
        int c;
        exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        exp_ready = '0;
        exp_din   = '0;
        if (m_owner >= 0) begin
            exp_din = req_data[m_owner*W +: W];
            if (req_valid[m_owner] && !fifo_full) exp_ready[m_owner] = 1'b1;
        end
        exp_push = |exp_ready;
        exp_tmo  = m_tmo;
        n_owner = m_owner; n_ptr = m_ptr; n_stall = m_stall; n_tmo = 1'b0;
        if (reset) begin
            n_owner = -1; n_ptr = 0; n_stall = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (req_valid[c]) begin
                    n_owner = c; n_stall = 0;
                    break;
                end
            end
        end else if (req_valid[m_owner]) begin
            n_stall = 0;
            if (!fifo_full && req_last[m_owner]) begin
                n_owner = -1; n_ptr = (m_owner + 1) % N;
            end
        end else if (m_stall == TMO - 1) begin
            n_owner = -1; n_ptr = (m_owner + 1) % N; n_stall = 0; n_tmo = 1'b1;
        end else begin
            n_stall = m_stall + 1;
        end
    endtask

    task automatic pre();
        src_drive();
        @(negedge clock);
        model_eval();
        obs_ready = req_ready;
        if (grant != '0 && last_grant == '0) order_q.push_back(oh_idx(grant));
        last_grant = grant;
    endtask

    task automatic post();
        @(posedge clock);
        m_owner = n_owner; m_ptr = n_ptr; m_stall = n_stall; m_tmo = n_tmo;
        src_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fifo_full = 1'b0; rand_mode = 1'b0;
        clear_srcs();
        pre(); post();
        reset = 1'b0;
        order_q.delete();
        last_grant = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fifo_full = 1'b0; rand_mode = 1'b0;
        clear_srcs();
        src_len[1] = 3; src_len[6] = 2;
        pre(); post();
        repeat (3) begin
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== '0) begin
                failures++;
                $display("FAIL reset_zero got g=%h r=%h p=%b d=%h e=%b want all zero",
                         grant, req_ready, fifo_push, fifo_din, timeout_err);
            end
            post();
        end
        reset = 1'b0;
        pre(); post();
        pre();
        checks++;
        if (grant !== 8'h02) begin
            failures++;
            $display("FAIL reset_first_grant got g=%h want 02", grant);
        end
        post();
    endtask

    task automatic test_single_packet();
        int base, pushes;
        do_reset();
        base = src_pkt[3]; pushes = 0;
        src_len[3] = 4;
        for (int cyc = 0; cyc < 8; cyc++) begin
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== {exp_grant, exp_ready, exp_push, exp_din, exp_tmo}) begin
                failures++;
                $display("FAIL single_model t=%0t got g=%h r=%h p=%b d=%h e=%b want g=%h r=%h p=%b d=%h e=%b",
                         $time, grant, req_ready, fifo_push, fifo_din, timeout_err, exp_grant, exp_ready, exp_push, exp_din, exp_tmo);
            end
            if (cyc == 0 || cyc == 1 || cyc == 5) begin
                checks++;
                if (grant !== ((cyc == 1) ? 8'h08 : 8'h00)) begin
                    failures++;
                    $display("FAIL single_grant cyc=%0d got g=%h", cyc, grant);
                end
            end
            if (fifo_push === 1'b1) begin
                checks++;
                if (fifo_din !== word_of(3, base, pushes) || cyc != pushes + 1) begin
                    failures++;
                    $display("FAIL single_order cyc=%0d got d=%h want d=%h at cyc %0d",
                             cyc, fifo_din, word_of(3, base, pushes), pushes + 1);
                end
                pushes++;
            end
            post();
        end
        checks++;
        if (pushes != 4) begin
            failures++;
            $display("FAIL single_count got %0d pushes want 4", pushes);
        end
        // Pointer must now sit at 4: with 3 and 4 both requesting, 4 wins
        src_len[3] = 1; src_len[4] = 1;
        pre(); post();
        pre();
        checks++;
        if (grant !== 8'h10) begin
            failures++;
            $display("FAIL single_ptr4 got g=%h want 10", grant);
        end
        post();
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 2; src_refill[i] = 2;
        end
        repeat (40) begin
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== {exp_grant, exp_ready, exp_push, exp_din, exp_tmo}) begin
                failures++;
                $display("FAIL fair_model t=%0t got g=%h r=%h p=%b d=%h e=%b want g=%h r=%h p=%b d=%h e=%b",
                         $time, grant, req_ready, fifo_push, fifo_din, timeout_err, exp_grant, exp_ready, exp_push, exp_din, exp_tmo);
            end
            post();
        end
        checks++;
        if (order_q.size() < 9) begin
            failures++;
            $display("FAIL fair_count got %0d grants want >= 9", order_q.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (order_q[k] != k % N) begin
                    failures++;
                    $display("FAIL fair_order slot=%0d got %0d want %0d", k, order_q[k], k % N);
                end
            end
        end
        clear_srcs();
    endtask

    task automatic test_backpressure();
        int pushes;
        logic [W-1:0] held;
        do_reset();
        src_len[5] = 4; pushes = 0;
        for (int c = 0; c < 10 && pushes < 2; c++) begin
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== {exp_grant, exp_ready, exp_push, exp_din, exp_tmo}) begin
                failures++;
                $display("FAIL bp_model t=%0t got g=%h r=%h p=%b d=%h e=%b want g=%h r=%h p=%b d=%h e=%b",
                         $time, grant, req_ready, fifo_push, fifo_din, timeout_err, exp_grant, exp_ready, exp_push, exp_din, exp_tmo);
            end
            if (fifo_push === 1'b1) pushes++;
            post();
        end
        checks++;
        if (pushes != 2) begin
            failures++;
            $display("FAIL bp_start got %0d pushes want 2", pushes);
        end
        held = word_of(5, src_pkt[5], src_widx[5]);
        fifo_full = 1'b1;
        repeat (10) begin
            pre();
            checks++;
            if ({fifo_push, req_ready, timeout_err, grant, fifo_din} !== {1'b0, 8'h00, 1'b0, 8'h20, held}) begin
                failures++;
                $display("FAIL bp_hold got p=%b r=%h e=%b g=%h d=%h want p=0 r=00 e=0 g=20 d=%h",
                         fifo_push, req_ready, timeout_err, grant, fifo_din, held);
            end
            post();
        end
        fifo_full = 1'b0;
        pre();
        checks++;
        if (fifo_push !== 1'b1 || fifo_din !== held) begin
            failures++;
            $display("FAIL bp_resume got p=%b d=%h want p=1 d=%h", fifo_push, fifo_din, held);
        end
        post();
        repeat (4) begin
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== {exp_grant, exp_ready, exp_push, exp_din, exp_tmo}) begin
                failures++;
                $display("FAIL bp_tail t=%0t got g=%h r=%h p=%b d=%h e=%b want g=%h r=%h p=%b d=%h e=%b",
                         $time, grant, req_ready, fifo_push, fifo_din, timeout_err, exp_grant, exp_ready, exp_push, exp_din, exp_tmo);
            end
            post();
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        src_len[5] = 1;
        repeat (4) begin pre(); post(); end
        order_q.delete();
        src_len[1] = 2; src_len[6] = 2;
        repeat (10) begin
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== {exp_grant, exp_ready, exp_push, exp_din, exp_tmo}) begin
                failures++;
                $display("FAIL wrap_model t=%0t got g=%h r=%h p=%b d=%h e=%b want g=%h r=%h p=%b d=%h e=%b",
                         $time, grant, req_ready, fifo_push, fifo_din, timeout_err, exp_grant, exp_ready, exp_push, exp_din, exp_tmo);
            end
            post();
        end
        checks++;
        if (order_q.size() != 2) begin
            failures++;
            $display("FAIL wrap_count got %0d grants want 2", order_q.size());
        end else begin
            checks++;
            if (order_q[0] != 6 || order_q[1] != 1) begin
                failures++;
                $display("FAIL wrap_order got %0d,%0d want 6,1", order_q[0], order_q[1]);
            end
        end
        src_len[6] = 1;
        repeat (4) begin pre(); post(); end
        order_q.delete();
        src_len[2] = 1;
        repeat (4) begin pre(); post(); end
        checks++;
        if (order_q.size() != 1 || order_q[0] != 2) begin
            failures++;
            $display("FAIL skip_grant got %0d grants first=%0d want one grant to 2",
                     order_q.size(), (order_q.size() > 0) ? order_q[0] : -1);
        end
    endtask

    task automatic test_timeout();
        int pushes, held, tmo_cnt, tmo_cyc;
        do_reset();
        src_len[2] = 3; pushes = 0;
        for (int c = 0; c < 6 && pushes == 0; c++) begin
            pre();
            if (fifo_push === 1'b1) pushes++;
            post();
        end
        src_hold[2] = 1'b1;
        src_len[4]  = 2;
        held = 0; tmo_cnt = 0; tmo_cyc = -1;
        for (int c = 0; c < 80; c++) begin
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== {exp_grant, exp_ready, exp_push, exp_din, exp_tmo}) begin
                failures++;
                $display("FAIL tmo_model t=%0t got g=%h r=%h p=%b d=%h e=%b want g=%h r=%h p=%b d=%h e=%b",
                         $time, grant, req_ready, fifo_push, fifo_din, timeout_err, exp_grant, exp_ready, exp_push, exp_din, exp_tmo);
            end
            if (grant === 8'h04) held++;
            if (timeout_err === 1'b1) begin
                tmo_cnt++;
                if (tmo_cyc < 0) tmo_cyc = c;
                checks++;
                if (grant !== 8'h00) begin
                    failures++;
                    $display("FAIL tmo_grant_drop got g=%h want 00", grant);
                end
            end
            if (tmo_cyc >= 0 && c == tmo_cyc + 1) begin
                checks++;
                if (grant !== 8'h10) begin
                    failures++;
                    $display("FAIL tmo_next_grant got g=%h want 10", grant);
                end
            end
            post();
        end
        checks++;
        if (held != TMO || tmo_cnt != 1) begin
            failures++;
            $display("FAIL tmo_window got held=%0d pulses=%0d want held=%0d pulses=1", held, tmo_cnt, TMO);
        end
        clear_srcs();
    endtask

    task automatic test_reset_mid_packet();
        bit fired;
        do_reset();
        src_len[5] = 1;
        repeat (4) begin pre(); post(); end
        src_len[0] = 6; fired = 1'b0;
        for (int c = 0; c < 12 && !fired; c++) begin
            if (last_grant === 8'h01 && src_widx[0] == 2) begin
                reset = 1'b1; fired = 1'b1;
            end
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== {exp_grant, exp_ready, exp_push, exp_din, exp_tmo}) begin
                failures++;
                $display("FAIL rstmid_model t=%0t got g=%h r=%h p=%b d=%h e=%b want g=%h r=%h p=%b d=%h e=%b",
                         $time, grant, req_ready, fifo_push, fifo_din, timeout_err, exp_grant, exp_ready, exp_push, exp_din, exp_tmo);
            end
            post();
        end
        checks++;
        if (!fired) begin
            failures++;
            $display("FAIL rstmid_fire got no word 3 from owner 0 want it within 12 cycles");
        end
        reset = 1'b0;
        clear_srcs();
        pre();
        checks++;
        if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got g=%h r=%h p=%b d=%h e=%b want all zero",
                     grant, req_ready, fifo_push, fifo_din, timeout_err);
        end
        post();
        // Pointer must be back at 0: requester 0 beats requester 7
        order_q.delete();
        src_len[0] = 2; src_len[7] = 2;
        repeat (8) begin pre(); post(); end
        checks++;
        if (order_q.size() < 1 || order_q[0] != 0) begin
            failures++;
            $display("FAIL rstmid_ptr got first=%0d want 0", (order_q.size() > 0) ? order_q[0] : -1);
        end
    endtask

    task automatic test_random();
        int left;
        do_reset();
        rand_mode = 1'b1; gap_pct = 15; full_pct = 25;
        for (int c = 0; c < 3000; c++) begin
            pre();
            checks++;
            if ({grant, req_ready, fifo_push, fifo_din, timeout_err} !== {exp_grant, exp_ready, exp_push, exp_din, exp_tmo}) begin
                failures++;
                $display("FAIL rand_model t=%0t got g=%h r=%h p=%b d=%h e=%b want g=%h r=%h p=%b d=%h e=%b",
                         $time, grant, req_ready, fifo_push, fifo_din, timeout_err, exp_grant, exp_ready, exp_push, exp_din, exp_tmo);
            end
            post();
        end
        rand_mode = 1'b0; fifo_full = 1'b0;
        repeat (200) begin pre(); post(); end
        left = 0;
        for (int i = 0; i < N; i++) left += src_len[i];
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL rand_drain got %0d words stuck want 0", left);
        end
    endtask

    initial begin
        reset = 1'b1; fifo_full = 1'b0; rand_mode = 1'b0; gap_pct = 0; full_pct = 0;
        req_valid = '0; req_last = '0; req_data = '0;
        obs_ready = '0; last_grant = '0;
        m_owner = -1; m_ptr = 0; m_stall = 0; m_tmo = 1'b0;
        n_owner = -1; n_ptr = 0; n_stall = 0; n_tmo = 1'b0;
        for (int i = 0; i < N; i++) src_pkt[i] = 0;
        clear_srcs();
        test_reset();
        test_single_packet();
        test_fairness();
        test_backpressure();
        test_wrap_skip();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/egress_arbiter.md
# egress_arbiter

Per-output-port packet arbiter between the eight ingress selectors and one egress FIFO. It grants one requesting selector at a time, chosen round-robin, and holds that grant for a whole packet. While granted, it muxes that selector's 32-bit words into the FIFO under FIFO-full backpressure. It sits in front of each `fifo3` instance, so concurrent packets from different inputs to the same output serialize cleanly instead of colliding on the push bus.

## Interface
Parameters:
- `NUM_REQ`, 8: number of requesting selectors.
- `DATA_W`, 32: word width.
- `TIMEOUT`, 64: maximum consecutive cycles a granted requester may leave `req_valid` low before its grant is revoked.

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `NUM_REQ`: requester i has a word available.
- `req_last`, in, `NUM_REQ`: the word offered by requester i is the last word of its packet.
- `req_data`, in, `NUM_REQ*DATA_W`: flattened words; requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_ready`, out, `NUM_REQ`: the word from requester i is accepted this cycle.
- `fifo_full`, in, 1: the egress FIFO cannot accept a push.
- `fifo_push`, out, 1: push strobe to the FIFO.
- `fifo_din`, out, `DATA_W`: word pushed to the FIFO.
- `grant`, out, `NUM_REQ`: one-hot current owner; all zero when idle.
- `timeout_err`, out, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- States are `IDLE` and `XFER`.
- `IDLE`:
  - If any `req_valid` is set, pick the first set bit at or after `rr_ptr`, searching upward and wrapping from 7 to 0.
  - Register the winner in `grant` and go to `XFER`.
  - If no request is present, stay in `IDLE`.
- `XFER`, with owner g:
  - `req_ready[g] = req_valid[g] & ~fifo_full`. All other `req_ready` bits are 0.
  - `fifo_push = req_ready[g]`.
  - `fifo_din = req_data[g]`. When `grant` is 0, `fifo_din` is 0.
  - An accepted word with `req_last[g]` set clears `grant`, sets `rr_ptr = (g+1) mod NUM_REQ` and returns to `IDLE`.
- Requests from non-owners are ignored mid-packet. They stay pending and are never dropped.
- Stall counter:
  - In `XFER`, it increments on each cycle where `req_valid[g]` is 0, and clears on each cycle where `req_valid[g]` is 1.
  - Cycles stalled only by `fifo_full` with `req_valid[g]` high do not count.
  - When the counter reaches `TIMEOUT-1` with `req_valid[g]` still low, the arbiter clears `grant`, advances `rr_ptr` past g, pulses `timeout_err` and returns to `IDLE`.
- The counter is `$clog2(TIMEOUT)` bits wide and saturates; it cannot wrap.
- `fifo_full` and `req_last` high in the same cycle: no accept, so the grant is held.
- `req_valid` is sampled only from the current owner; other requesters' `req_last` is don't-care.

## Timing
- Reset values: `grant` 0, `req_ready` 0, `fifo_push` 0, `fifo_din` 0, `timeout_err` 0, `rr_ptr` 0, state `IDLE`, stall counter 0.
- Reset asserted mid-packet aborts the packet in the next cycle. The requester must restart it.
- Grant latency: a request arriving in `IDLE` at cycle n gives `grant` valid at cycle n+1. The first word can be pushed at n+1.
- `req_ready`, `fifo_push` and `fifo_din` are combinational from the registered `grant`, `req_valid` and `fifo_full`. There is no added data latency.
- Throughput: one word per cycle while the owner is valid and the FIFO is not full.
- Packet boundary costs exactly one `IDLE` cycle before the next grant.
- A one-word packet (valid and last together on the first `XFER` cycle) occupies two cycles in total: `IDLE`, then `XFER`.
- `timeout_err` is high for exactly the one cycle in which `grant` drops.

## Structure
- Shared `router_pkg`: `NUM_PORTS` (8), `DATA_W` (32), the arbiter state enum `{IDLE, XFER}`, and the `rr_ptr` width `$clog2(NUM_PORTS)`.
- One sub-module, `rr_pick`:
  - Combinational round-robin priority encoder.
  - Inputs: `req` vector and `ptr`. Outputs: one-hot `winner` and `any`.
  - Reusable by later allocators.
- The top level holds the state register, `grant`, `rr_ptr`, the stall counter and the data mux.

## Test plan
- Single packet: `req_valid[3]` with 4 words, `last` on word 4, `fifo_full`=0 → `grant`=`8'h08` one cycle after request; 4 consecutive pushes in order; `grant`=0 after the last word; `rr_ptr`=4.
- Fairness: all 8 requesters valid continuously with 2-word packets from reset → grant order 0,1,2,…,7,0. Each owner pushes 2 words, followed by one idle cycle between owners.
- Backpressure: owner 5 mid-packet, `fifo_full` held high for 10 cycles → `fifo_push`=0 and `req_ready`=0 throughout; no timeout; the word is held; transfer resumes when `fifo_full` falls.
- Wrap and skip: `rr_ptr`=6, requests on bits 1 and 6 → 6 granted first, then 1. With `rr_ptr`=7 and a request only on bit 2 → 2 granted.
- Timeout: owner 2 drops `req_valid` for `TIMEOUT` cycles (64) → `timeout_err` pulses once on cycle 64, `grant` clears, and a pending requester 4 is granted the next cycle.
- Reset mid-packet: `reset` high during word 3 of 6 from owner 0 → next cycle all outputs are at reset values and `rr_ptr`=0; a new request from 0 is granted normally.
